text_console_buffer: RTL
========================

// Module: text_console_buffer
// PURPOSE
// - Character/attribute screen memory feeding the console glyph renderer.
// - Accepts a byte stream of {attribute, ASCII} over valid/ready.
// - Stores it as an 80x30 grid with cursor, CR/LF/BS handling and hardware scroll.
// - Returns the character and attribute for the cell under (cx, cy) from the HDMI timing generator.
// PARAMETERS
// - COLS         80     text columns (8-px glyphs, 640 px)
// - ROWS         30     text rows (16-px glyphs, 480 px)
// - CLEAR_ATTR   8'h0F  attribute written by clear operations
// PORTS
// - clk_pixel  in   1   pixel clock; single clock domain
// - rst_n      in   1   asynchronous active-low reset
// - in_valid   in   1   input byte valid
// - in_char    in   8   ASCII code
// - in_attr    in   8   attribute for in_char
// - in_ready   out  1   block accepts byte this cycle (handshake when in_valid & in_ready)
// - cx         in   10  current pixel x from hdmi
// - cy         in   10  current pixel y from hdmi
// - character  out  8   glyph code for console
// - attribute  out  8   attribute for console
// - cursor_col out  7   current cursor column, 0..COLS-1
// - cursor_row out  5   current cursor display row, 0..ROWS-1
// BEHAVIOUR
// - Reset values:
//   - in_ready=0, character=0, attribute=0, cursor_col=0, cursor_row=0.
//   - Internal top_row=0; FSM=CLEAR_ALL.
// - Storage:
//   - Simple dual-port RAM, COLS*ROWS x 16 bit; one write port, one read port; contents not reset.
//   - Physical row of display row r = (r + top_row) mod ROWS.
//   - Address = phys_row*COLS + col.
// - FSM:
//   - CLEAR_ALL: write {CLEAR_ATTR,8'h20} to one address per cycle, 0..COLS*ROWS-1 (2400 cycles); then IDLE.
//   - IDLE: in_ready=1; handles accepted bytes in 1 cycle.
//   - CLEAR_LINE: in_ready=0; writes COLS blanks to the new bottom physical row (80 cycles); then IDLE.
// - Byte handling (IDLE, on handshake):
//   - 8'h0D CR: col <= 0.
//   - 8'h0A LF: col <= 0; row+1. At row ROWS-1: stay on row, scroll.
//   - 8'h08 BS: col <= col-1 when col>0; no erase. At col 0: no-op.
//   - Any other code: write {in_attr,in_char} at cursor; col+1.
//     - At col COLS-1: col <= 0, advance row as for LF (scroll at bottom).
// - Scroll: top_row <= (top_row+1) mod ROWS, enter CLEAR_LINE on the physical row that was top_row.
//   - Cursor stays at row ROWS-1.
// - Read path:
//   - Cell = (cx[9:3], cy[8:4]).
//   - RAM read registered; character/attribute valid 2 clk_pixel after cx/cy (addr reg + RAM reg).
//   - console sees the value mid-glyph; it compensates via its fixed pipeline.
// - Blanking: cx>=COLS*8 or cy>=ROWS*16 -> character=0, attribute=0 (same 2-cycle latency).
// - Concurrency: read port independent of writes.
//   - A same-address read/write returns old data; one-frame artefact acceptable.
// - Reset mid-operation: async reset aborts any clear.
//   - Returns to CLEAR_ALL; full clear repeats; input ignored until done.
// - Widths: top_row and row arithmetic 5 bit mod ROWS, compare-and-wrap, no power-of-2 assumption.
//   - Address multiply done as (row<<6)+(row<<4) for COLS=80; generic path via constant multiply.
// STRUCTURE
// - Shared package (console_pkg): COLS, ROWS, GLYPH_W=8, GLYPH_H=16, ASCII_CR/LF/BS/SPACE, FSM state enum.
//   - Same package used by console.
// - Sub-module: text_ram — inferred simple dual-port RAM, registered read, 16-bit x COLS*ROWS.
// - Top of block: FSM, cursor/scroll logic, read address pipeline.
// TESTING
// - Reset release -> in_ready low 2400 cycles, then high; every visible cell reads 8'h20/CLEAR_ATTR.
// - Send 'A'(8'h41, attr 8'h1E) after clear -> cursor_col=1.
//   - cx=0..7, cy=0..15 read 8'h41/8'h1E 2 cycles later; cell (1,0) still blank.
// - 80 bytes 'x' on row 0 -> cursor wraps to col 0 row 1; cell (79,0)='x'.
// - 30 LFs, then 'B' -> one scroll.
//   - in_ready low 80 cycles; old row 1 content shown on display row 0.
//   - 'B' at (0,29); display row 29 otherwise blank.
// - BS at col 0 -> no change; 'C', BS, 'D' -> cell (0,r)='D', col=1.
// - Assert rst_n low during CLEAR_LINE -> outputs zero immediately; full 2400-cycle clear reruns.

Source files
------------

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared text console geometry, control codes, FSM states and address helpers
package console_pkg;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CELLS   = COLS * ROWS;
    localparam int ADDR_W  = $clog2(CELLS);
    localparam int COL_W   = 7;
    localparam int ROW_W   = 5;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL,
        ST_IDLE,
        ST_CLEAR_LINE
    } con_state_e;

    // Display row -> physical row, with top_row as the scroll offset.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, row} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        if (COLS == 80) begin
            return (r << 6) + (r << 4) + ADDR_W'(col);
        end
        return r * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/text_ram.sv
// rtl/text_ram.sv - simple dual-port screen RAM, one write port, registered read port
module text_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Read and write share one process so a same-address access returns old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/text_console_buffer.sv
// rtl/text_console_buffer.sv - 80x30 character/attribute screen with cursor, scroll and pixel read path
module text_console_buffer
    import console_pkg::*;
#(
    parameter logic [7:0] CLEAR_ATTR = 8'h0F
) (
    input  logic                 clk_pixel,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_char,
    input  logic [7:0]           in_attr,
    output logic                 in_ready,
    input  logic [9:0]           cx,
    input  logic [9:0]           cy,
    output logic [7:0]           character,
    output logic [7:0]           attribute,
    output logic [COL_W-1:0]     cursor_col,
    output logic [ROW_W-1:0]     cursor_row
);

    con_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [COL_W-1:0]   clr_col_q, clr_col_d;
    logic [ROW_W-1:0]   clr_row_q, clr_row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   top_q, top_d;

    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               vis1_q, vis1_d;
    logic               vis2_q, vis2_d;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [15:0]        wdata;
    logic [15:0]        rdata;
    logic               advance;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_col_d  = clr_col_q;
        clr_row_d  = clr_row_q;
        col_d      = col_q;
        row_d      = row_q;
        top_d      = top_q;
        in_ready   = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = {CLEAR_ATTR, ASCII_SPACE};
        advance    = 1'b0;

        unique case (state_q)
            ST_CLEAR_ALL: begin
                we    = 1'b1;
                waddr = clr_addr_q;
                if (clr_addr_q == ADDR_W'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end

            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (in_char)
                        ASCII_CR: col_d = '0;
                        ASCII_LF: begin
                            col_d   = '0;
                            advance = 1'b1;
                        end
                        ASCII_BS: begin
                            if (col_q != '0) begin
                                col_d = col_q - 1'b1;
                            end
                        end
                        default: begin
                            we    = 1'b1;
                            waddr = cell_addr(phys_row(row_q, top_q), col_q);
                            wdata = {in_attr, in_char};
                            if (col_q == COL_LAST) begin
                                col_d   = '0;
                                advance = 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    endcase

                    // The old top physical row becomes the new bottom line once top_row moves.
                    if (advance) begin
                        if (row_q == ROW_LAST) begin
                            top_d     = (top_q == ROW_LAST) ? '0 : top_q + 1'b1;
                            clr_row_d = top_q;
                            clr_col_d = '0;
                            state_d   = ST_CLEAR_LINE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
            end

            ST_CLEAR_LINE: begin
                we    = 1'b1;
                waddr = cell_addr(clr_row_q, clr_col_q);
                if (clr_col_q == COL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_col_d = clr_col_q + 1'b1;
                end
            end

            default: state_d = ST_CLEAR_ALL;
        endcase
    end

    always_comb begin
        vis1_d  = (cx < 10'(COLS * GLYPH_W)) && (cy < 10'(ROWS * GLYPH_H));
        raddr_d = vis1_d ? cell_addr(phys_row(cy[8:4], top_q), cx[9:3]) : '0;
        vis2_d  = vis1_q;
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR_ALL;
            clr_addr_q <= '0;
            clr_col_q  <= '0;
            clr_row_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            top_q      <= '0;
            raddr_q    <= '0;
            vis1_q     <= 1'b0;
            vis2_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_col_q  <= clr_col_d;
            clr_row_q  <= clr_row_d;
            col_q      <= col_d;
            row_q      <= row_d;
            top_q      <= top_d;
            raddr_q    <= raddr_d;
            vis1_q     <= vis1_d;
            vis2_q     <= vis2_d;
        end
    end

    text_ram #(
        .DEPTH (CELLS),
        .AW    (ADDR_W),
        .DW    (16)
    ) u_text_ram (
        .clk   (clk_pixel),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr_q),
        .rdata (rdata)
    );

    assign character  = vis2_q ? rdata[7:0]  : 8'h00;
    assign attribute  = vis2_q ? rdata[15:8] : 8'h00;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule
